// File: rtl/cpu_jtag_debug_host_shifter_if.sv
// Command/response channel between a system-clock debug master and the
// on-chip virtual-JTAG host shifter.
//   cmd_valid/cmd_ready : scan request handshake (master -> host)
//   cmd_ir/cmd_data     : virtual IR value and DR value for the scan
//   rsp_valid/rsp_ready : scan result handshake (host -> master)
//   rsp_data            : DR value captured from tdo
//   rsp_ir_out          : slave ir_out sampled during UIR (zero unless readback is built in)
// Modports: master = command source, slave = host shifter.
interface cpu_jtag_debug_host_shifter_if #(
  parameter int DR_W = 38,
  parameter int IR_W = 2
) ();
  logic            cmd_valid;
  logic            cmd_ready;
  logic [IR_W-1:0] cmd_ir;
  logic [DR_W-1:0] cmd_data;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DR_W-1:0] rsp_data;
  logic [IR_W-1:0] rsp_ir_out;

  modport master (
    output cmd_valid, cmd_ir, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ir_out
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_ir_out
  );
endinterface

// File: rtl/cpu_jtag_debug_host_shifter.sv
// On-chip host for the CPU debug module's virtual-JTAG slave port. It plays
// the role of sld_virtual_jtag_basic: generates tck/tdi, presents ir_in and
// walks the slave through UIR -> CDR -> SDR (DR_W bits) -> UDR, returning the
// DR value shifted out of tdo.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   bus (slave)     cmd_* request / rsp_* response channel
//   tck, tdi, tdo   generated test clock and serial data
//   ir_in, ir_out   virtual IR to the slave / IR status from the slave
//   vs_uir/cdr/sdr/udr  virtual state strobes, one per scan phase
//   jtag_state_rti  high while idle or holding a response
// Optional feature: define CPU_JTAG_HOST_IR_READBACK_EN to sample ir_out on
// the last clk of UIR and return it in rsp_ir_out; otherwise rsp_ir_out = 0.
module cpu_jtag_debug_host_shifter #(
  parameter int DR_W     = 38,
  parameter int IR_W     = 2,
  parameter int TCK_HALF = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  cpu_jtag_debug_host_shifter_if.slave       bus,
  output logic                               tck,
  output logic                               tdi,
  input  logic                               tdo,
  output logic [IR_W-1:0]                    ir_in,
  input  logic [IR_W-1:0]                    ir_out,
  output logic                               vs_uir,
  output logic                               vs_cdr,
  output logic                               vs_sdr,
  output logic                               vs_udr,
  output logic                               jtag_state_rti
);

  localparam int DIV_W = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
  localparam int BIT_W = $clog2(DR_W + 1);

  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RSP} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DR_W-1:0]   shreg;

  // The shift register doubles as the response register: once the scan is
  // over it holds exactly the bits captured from tdo.
  assign bus.rsp_data = shreg;

`ifdef CPU_JTAG_HOST_IR_READBACK_EN
  logic [IR_W-1:0] ir_cap;
`else
  logic unused_ir_out;
  assign unused_ir_out  = ^ir_out;
  assign bus.rsp_ir_out = '0;
`endif

  // Scan sequencer. All outputs are registered and updated together with the
  // state so that the strobes, tck and tdi line up exactly. Phase changes are
  // taken only on the clk where tck falls, and tdi is only reloaded there,
  // so the slave always sees tdi stable across its tck rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      div_cnt        <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      tck            <= 1'b0;
      tdi            <= 1'b0;
      ir_in          <= '0;
      vs_uir         <= 1'b0;
      vs_cdr         <= 1'b0;
      vs_sdr         <= 1'b0;
      vs_udr         <= 1'b0;
      jtag_state_rti <= 1'b1;
      bus.cmd_ready  <= 1'b0;
      bus.rsp_valid  <= 1'b0;
`ifdef CPU_JTAG_HOST_IR_READBACK_EN
      ir_cap         <= '0;
      bus.rsp_ir_out <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_ready && bus.cmd_valid) begin
            ir_in          <= bus.cmd_ir;
            shreg          <= bus.cmd_data;
            bit_cnt        <= '0;
            div_cnt        <= '0;
            tck            <= 1'b0;
            bus.cmd_ready  <= 1'b0;
            vs_uir         <= 1'b1;
            jtag_state_rti <= 1'b0;
            state          <= UIR;
          end else begin
            bus.cmd_ready <= 1'b1;
          end
        end

        // First RSP clk raises rsp_valid; the handshake then returns to IDLE,
        // where cmd_ready comes back one clk later.
        RSP: begin
          if (!bus.rsp_valid) begin
            bus.rsp_valid  <= 1'b1;
`ifdef CPU_JTAG_HOST_IR_READBACK_EN
            bus.rsp_ir_out <= ir_cap;
`endif
          end else if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end

        default: begin
          if (div_cnt == DIV_W'(TCK_HALF - 1)) begin
            div_cnt <= '0;
            tck     <= ~tck;
            if (!tck) begin
              // tck rising: sample tdo into the top of the shift register.
              if (state == SDR) begin
                shreg   <= {tdo, shreg[DR_W-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              // tck falling: advance the phase and present the next tdi bit.
              case (state)
                UIR: begin
                  vs_uir <= 1'b0;
                  vs_cdr <= 1'b1;
                  state  <= CDR;
`ifdef CPU_JTAG_HOST_IR_READBACK_EN
                  ir_cap <= ir_out;
`endif
                end
                CDR: begin
                  vs_cdr <= 1'b0;
                  vs_sdr <= 1'b1;
                  tdi    <= shreg[0];
                  state  <= SDR;
                end
                SDR: begin
                  if (bit_cnt == BIT_W'(DR_W)) begin
                    vs_sdr <= 1'b0;
                    vs_udr <= 1'b1;
                    tdi    <= 1'b0;
                    state  <= UDR;
                  end else begin
                    tdi <= shreg[0];
                  end
                end
                UDR: begin
                  vs_udr         <= 1'b0;
                  jtag_state_rti <= 1'b1;
                  state          <= RSP;
                end
                default: ;
              endcase
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
